gsense_train_supervisor: RTL and testbench

// - Bring-up/retry sequencer for the GSENSE LVDS receiver, upstream of the serdes top.
// - Drives the receiver's reset and enable inputs.
// - Watches training_done and lane lock, with a timeout and bounded retries.
// - Reports link status to the system controller.
// - Runs entirely in the 200MHz idlyctrl_clk domain; status inputs from the clkdiv2 domain are 2-FF synchronised here.

---
 rtl/gsense_train_supervisor.sv | 166 ++++++++++++++++
 tb/tb_gsense_train_supervisor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gsense_train_supervisor.sv
// Bring-up/retry sequencer for the GSENSE LVDS receiver: drives serdes reset/enable,
// supervises training_done and lane lock. Option: GSENSE_SUP_AUTO_RETRAIN_EN retrains on lock loss.
module gsense_train_supervisor #(
  parameter int unsigned LANES          = 32,
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned SETTLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned MAX_RETRIES    = 4,
  parameter int unsigned LOSS_FILTER    = 64
) (
  input  logic             idlyctrl_clk,
  input  logic             reset,
  input  logic             start,
  input  logic             training_done,
  input  logic [LANES-1:0] lane_locked,
  output logic             serdes_reset,
  output logic             serdes_enable,
  output logic             busy,
  output logic             link_up,
  output logic             fail,
  output logic             lock_lost,
  output logic [3:0]       retry_count
);

  localparam int unsigned MAX_A   = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_B   = (TIMEOUT_CYCLES > LOSS_FILTER) ? TIMEOUT_CYCLES : LOSS_FILTER;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_SETTLE, S_ENABLE, S_WAIT_DONE, S_LINK_UP, S_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_d;
  logic             lock_lost_d;

  logic             start_m, start_s, start_q;
  logic             done_m, done_s;
  logic [LANES-1:0] locked_m, locked_s;
  logic             start_rise, all_locked;

  // 2-FF synchronisers for the clkdiv2-domain status and the start level
  always_ff @(posedge idlyctrl_clk or posedge reset) begin
    if (reset) begin
      start_m  <= 1'b0;
      start_s  <= 1'b0;
      start_q  <= 1'b0;
      done_m   <= 1'b0;
      done_s   <= 1'b0;
      locked_m <= '0;
      locked_s <= '0;
    end else begin
      start_m  <= start;
      start_s  <= start_m;
      start_q  <= start_s;
      done_m   <= training_done;
      done_s   <= done_m;
      locked_m <= lane_locked;
      locked_s <= locked_m;
    end
  end

  assign start_rise = start_s & ~start_q;
  assign all_locked = &locked_s;

  // State, counters and registered outputs (outputs follow the state one clock later)
  always_ff @(posedge idlyctrl_clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      retry_count   <= 4'd0;
      lock_lost     <= 1'b0;
      serdes_reset  <= 1'b1;
      serdes_enable <= 1'b0;
      busy          <= 1'b0;
      link_up       <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_count   <= retry_d;
      lock_lost     <= lock_lost_d;
      serdes_reset  <= (state_q inside {S_IDLE, S_RESET, S_FAIL});
      serdes_enable <= (state_q inside {S_ENABLE, S_WAIT_DONE, S_LINK_UP});
      busy          <= (state_q inside {S_RESET, S_SETTLE, S_ENABLE, S_WAIT_DONE});
      link_up       <= (state_q == S_LINK_UP);
      fail          <= (state_q == S_FAIL);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
    retry_d     = retry_count;
    lock_lost_d = lock_lost;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_rise) begin
          state_d     = S_RESET;
          retry_d     = 4'd0;
          lock_lost_d = 1'b0;
        end
      end
      S_RESET: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_ENABLE;
          cnt_d   = '0;
        end
      end
      S_ENABLE: begin
        state_d = S_WAIT_DONE;
        cnt_d   = '0;
      end
      S_WAIT_DONE: begin
        // done takes priority over a coincident timeout
        if (done_s) begin
          state_d = S_LINK_UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          cnt_d   = '0;
          retry_d = retry_count + 4'd1;
          state_d = (retry_d == 4'(MAX_RETRIES)) ? S_FAIL : S_RESET;
        end
      end
      S_LINK_UP: begin
        if (all_locked) cnt_d = '0;
        else if (cnt_q == CNT_W'(LOSS_FILTER)) cnt_d = cnt_q;
        if (cnt_q == CNT_W'(LOSS_FILTER)) begin
          lock_lost_d = 1'b1;
`ifdef GSENSE_SUP_AUTO_RETRAIN_EN
          state_d = S_RESET;
          cnt_d   = '0;
`endif
        end
        if (start_rise) begin
          state_d     = S_RESET;
          cnt_d       = '0;
          retry_d     = 4'd0;
          lock_lost_d = 1'b0;
        end
      end
      S_FAIL: begin
        cnt_d = '0;
        if (start_rise) begin
          state_d     = S_RESET;
          retry_d     = 4'd0;
          lock_lost_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_gsense_train_supervisor.sv
// Directed self-checking bench for gsense_train_supervisor with small test parameters.
module tb_gsense_train_supervisor;

  logic       idlyctrl_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       training_done = 1'b0;
  logic [3:0] lane_locked = 4'b1111;
  logic       serdes_reset, serdes_enable, busy, link_up, fail, lock_lost;
  logic [3:0] retry_count;

  int n_checks = 0;
  int n_err = 0;
  int n;

  gsense_train_supervisor #(
    .LANES(4), .RST_CYCLES(16), .SETTLE_CYCLES(8), .TIMEOUT_CYCLES(100),
    .MAX_RETRIES(3), .LOSS_FILTER(4)
  ) dut (
    .idlyctrl_clk (idlyctrl_clk),
    .reset        (reset),
    .start        (start),
    .training_done(training_done),
    .lane_locked  (lane_locked),
    .serdes_reset (serdes_reset),
    .serdes_enable(serdes_enable),
    .busy         (busy),
    .link_up      (link_up),
    .fail         (fail),
    .lock_lost    (lock_lost),
    .retry_count  (retry_count)
  );

  always #5 idlyctrl_clk = ~idlyctrl_clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge idlyctrl_clk);
    #1;
  endtask

  function automatic bit sig(input int which);
    case (which)
      0:       return serdes_reset;
      1:       return serdes_enable;
      2:       return busy;
      3:       return link_up;
      4:       return fail;
      default: return lock_lost;
    endcase
  endfunction

  // Wait (bounded) for an output to reach a level; the final compare flags an expired bound
  task automatic wait_sig(input string tag, input int which, input bit val, input int bound,
                          output int cycles);
    cycles = 0;
    while (sig(which) != val && cycles < bound) begin
      step();
      cycles++;
    end
    check(tag, sig(which), val);
  endtask

  // From an accepted start: measure RESET and SETTLE phase lengths up to the first enable-high sample
  task automatic bringup_phase(input bit toggle_in_settle);
    int c;
    wait_sig("busy_rise", 2, 1'b1, 20, c);
    check("fail_clear_at_start", fail, 0);
    check("retry_clear_at_start", retry_count, 0);
    c = 0;
    while (serdes_reset && c < 100) begin
      step();
      c++;
    end
    check("reset_len", c, 16);
    c = 0;
    while (!serdes_enable && c < 100) begin
      if (toggle_in_settle && c == 2) start = 1'b0;
      if (toggle_in_settle && c == 4) start = 1'b1;
      step();
      c++;
    end
    check("settle_len", c, 8);
    check("busy_in_enable", busy, 1);
  endtask

  initial begin
    repeat (3) step();
    check("rst_serdes_reset", serdes_reset, 1);
    check("rst_enable", serdes_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_link_up", link_up, 0);
    check("rst_fail", fail, 0);
    check("rst_lock_lost", lock_lost, 0);
    check("rst_retry", retry_count, 0);
    reset = 1'b0;
    repeat (2) step();

    // Nominal bring-up: done 20 cycles after enable rises
    start = 1'b1;
    bringup_phase(1'b0);
    repeat (20) step();
    training_done = 1'b1;
    wait_sig("nom_link_up", 3, 1'b1, 10, n);
    check("nom_link_latency_le4", (n <= 4) ? 1 : 0, 1);
    check("nom_retry", retry_count, 0);
    check("nom_busy", busy, 0);
    check("nom_enable", serdes_enable, 1);

    // Short lock drop (3 cycles) stays below the loss filter
    lane_locked = 4'b1011;
    repeat (3) step();
    lane_locked = 4'b1111;
    repeat (10) step();
    check("short_drop_lock_lost", lock_lost, 0);
    check("short_drop_link_up", link_up, 1);

    // Four-cycle drop reaches the loss filter
    lane_locked = 4'b1011;
    repeat (4) step();
    lane_locked = 4'b1111;
    repeat (10) step();
    check("long_drop_lock_lost", lock_lost, 1);
`ifdef GSENSE_SUP_AUTO_RETRAIN_EN
    check("retrain_link_up", link_up, 0);
    check("retrain_busy", busy, 1);
    check("retrain_serdes_reset", serdes_reset, 1);
    check("retrain_retry", retry_count, 0);
`else
    check("long_drop_link_up", link_up, 1);
    check("long_drop_busy", busy, 0);
`endif

    // Timeout and retries: done held low
    training_done = 1'b0;
    start = 1'b0;
    repeat (4) step();
    start = 1'b1;
    wait_sig("to_busy", 2, 1'b1, 20, n);
`ifndef GSENSE_SUP_AUTO_RETRAIN_EN
    check("to_lock_lost_cleared", lock_lost, 0);
`endif
    for (int i = 1; i <= 3; i++) begin
      wait_sig("to_enable_rise", 1, 1'b1, 200, n);
      n = 0;
      while (serdes_enable && n < 300) begin
        step();
        n++;
      end
      check("to_enable_len", n, 101);
      check("to_retry_count", retry_count, i);
    end
    check("to_fail", fail, 1);
    check("to_serdes_reset", serdes_reset, 1);
    check("to_busy_low", busy, 0);
    repeat (5) step();
    check("to_fail_held", fail, 1);
    check("to_retry_held", retry_count, 3);

    // Restart from FAIL, with an ignored start toggle during SETTLE
    start = 1'b0;
    repeat (4) step();
    start = 1'b1;
    bringup_phase(1'b1);
    n = 0;
    while (serdes_enable && n < 300) begin
      step();
      n++;
    end
    check("rec_attempt1_len", n, 101);
    check("rec_retry_after1", retry_count, 1);
    wait_sig("rec_enable2", 1, 1'b1, 100, n);
    repeat (10) step();
    training_done = 1'b1;
    wait_sig("rec_link_up", 3, 1'b1, 10, n);
    check("rec_retry", retry_count, 1);
    check("rec_fail", fail, 0);

    // Mid-run reset during WAIT_DONE
    training_done = 1'b0;
    start = 1'b0;
    repeat (4) step();
    start = 1'b1;
    wait_sig("mid_busy", 2, 1'b1, 20, n);
    start = 1'b0;
    wait_sig("mid_enable", 1, 1'b1, 100, n);
    repeat (10) step();
    reset = 1'b1;
    step();
    check("mid_serdes_reset", serdes_reset, 1);
    check("mid_enable_low", serdes_enable, 0);
    check("mid_busy_low", busy, 0);
    check("mid_link_up", link_up, 0);
    check("mid_fail", fail, 0);
    check("mid_lock_lost", lock_lost, 0);
    check("mid_retry", retry_count, 0);
    reset = 1'b0;
    repeat (5) step();
    check("mid_idle_busy", busy, 0);
    check("mid_idle_serdes_reset", serdes_reset, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
